// File: rtl/scarv_cop_mem_arb_pkg.sv
// Shared constants for the COP memory arbiter: requester indices and lock states.
package scarv_cop_mem_arb_pkg;

    localparam logic SCARV_COP_ARB_R0 = 1'b0;
    localparam logic SCARV_COP_ARB_R1 = 1'b1;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/scarv_cop_arb_pick.sv
// Combinational grant selector. Define SCARV_COP_ARB_ROUND_ROBIN_EN for
// round-robin contention; otherwise requester 0 has fixed priority.
module scarv_cop_arb_pick
    import scarv_cop_mem_arb_pkg::*;
(
    input  logic lock,
    input  logic owner,
    input  logic last,
    input  logic r0_cen,
    input  logic r1_cen,
    output logic gnt_valid,
    output logic gnt_idx
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = SCARV_COP_ARB_R0;
        if (lock) begin
            gnt_valid = 1'b1;
            gnt_idx   = owner;
        end else if (r0_cen && r1_cen) begin
            gnt_valid = 1'b1;
`ifdef SCARV_COP_ARB_ROUND_ROBIN_EN
            gnt_idx   = ~last;
`else
            gnt_idx   = SCARV_COP_ARB_R0;
`endif
        end else if (r0_cen) begin
            gnt_valid = 1'b1;
            gnt_idx   = SCARV_COP_ARB_R0;
        end else if (r1_cen) begin
            gnt_valid = 1'b1;
            gnt_idx   = SCARV_COP_ARB_R1;
        end
    end

`ifndef SCARV_COP_ARB_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/scarv_cop_mem_arb.sv
// Two-requester arbiter for the COP memory bus with zero added latency.
// Policy selected by SCARV_COP_ARB_ROUND_ROBIN_EN (see scarv_cop_arb_pick).
module scarv_cop_mem_arb
    import scarv_cop_mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            r0_cen,
    input  logic            r0_wen,
    input  logic [AW-1:0]   r0_addr,
    input  logic [DW-1:0]   r0_wdata,
    input  logic [DW/8-1:0] r0_ben,
    output logic [DW-1:0]   r0_rdata,
    output logic            r0_stall,
    output logic            r0_error,
    input  logic            r1_cen,
    input  logic            r1_wen,
    input  logic [AW-1:0]   r1_addr,
    input  logic [DW-1:0]   r1_wdata,
    input  logic [DW/8-1:0] r1_ben,
    output logic [DW-1:0]   r1_rdata,
    output logic            r1_stall,
    output logic            r1_error,
    output logic            mem_cen,
    output logic            mem_wen,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_ben,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_stall,
    input  logic            mem_error,
    output logic            dbg_lock,
    output logic            dbg_owner
);

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       lock_eff;
    logic       gnt_valid, gnt_idx;
    logic       gnt_r0, gnt_r1;
    logic       mem_done;

    // Lock is forced open while reset is held so requests still pass through.
    assign lock_eff = (state_q == ARB_LOCKED) && g_resetn;

    scarv_cop_arb_pick u_pick (
        .lock      (lock_eff),
        .owner     (owner_q),
        .last      (last_q),
        .r0_cen    (r0_cen),
        .r1_cen    (r1_cen),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign gnt_r0   = gnt_valid && (gnt_idx == SCARV_COP_ARB_R0);
    assign gnt_r1   = gnt_valid && (gnt_idx == SCARV_COP_ARB_R1);
    assign mem_done = mem_cen && !mem_stall;

    always_comb begin
        mem_cen   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ben   = '0;
        if (gnt_r0) begin
            mem_cen   = r0_cen;
            mem_wen   = r0_wen;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
            mem_ben   = r0_ben;
        end else if (gnt_r1) begin
            mem_cen   = r1_cen;
            mem_wen   = r1_wen;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
            mem_ben   = r1_ben;
        end
    end

    // Response data only escapes in a real completion cycle.
    assign r0_stall = gnt_r0 ? mem_stall : r0_cen;
    assign r1_stall = gnt_r1 ? mem_stall : r1_cen;
    assign r0_rdata = (gnt_r0 && mem_done) ? mem_rdata : '0;
    assign r1_rdata = (gnt_r1 && mem_done) ? mem_rdata : '0;
    assign r0_error = gnt_r0 && mem_done && mem_error;
    assign r1_error = gnt_r1 && mem_done && mem_error;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ARB_OPEN: begin
                if (gnt_valid && mem_stall) begin
                    state_d = ARB_LOCKED;
                    owner_d = gnt_idx;
                end
            end
            ARB_LOCKED: begin
                // An owner that drops cen abandons its slot as well.
                if (!mem_stall || !mem_cen) begin
                    state_d = ARB_OPEN;
                end
            end
            default: state_d = ARB_OPEN;
        endcase
        if (mem_done) begin
            last_d = gnt_idx;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ARB_OPEN;
            owner_q <= SCARV_COP_ARB_R0;
            last_q  <= SCARV_COP_ARB_R1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign dbg_lock  = (state_q == ARB_LOCKED);
    assign dbg_owner = owner_q;

endmodule

// File: tb/tb_scarv_cop_mem_arb.sv
// Directed scoreboard bench for scarv_cop_mem_arb; expectations follow
// SCARV_COP_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_scarv_cop_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          g_clk    = 1'b0;
    logic          g_resetn = 1'b0;
    logic          r0_cen = 1'b0, r0_wen = 1'b0;
    logic [31:0]   r0_addr = '0, r0_wdata = '0;
    logic [3:0]    r0_ben = '0;
    logic          r1_cen = 1'b0, r1_wen = 1'b0;
    logic [31:0]   r1_addr = '0, r1_wdata = '0;
    logic [3:0]    r1_ben = '0;
    logic [31:0]   r0_rdata, r1_rdata;
    logic          r0_stall, r1_stall, r0_error, r1_error;
    logic          mem_cen, mem_wen;
    logic [31:0]   mem_addr, mem_wdata;
    logic [3:0]    mem_ben;
    logic [31:0]   mem_rdata = '0;
    logic          mem_stall = 1'b0, mem_error = 1'b0;
    logic          dbg_lock, dbg_owner;

    always #5 g_clk = ~g_clk;

    scarv_cop_mem_arb #(.AW(AW), .DW(DW)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .r0_cen    (r0_cen),
        .r0_wen    (r0_wen),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_ben    (r0_ben),
        .r0_rdata  (r0_rdata),
        .r0_stall  (r0_stall),
        .r0_error  (r0_error),
        .r1_cen    (r1_cen),
        .r1_wen    (r1_wen),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_ben    (r1_ben),
        .r1_rdata  (r1_rdata),
        .r1_stall  (r1_stall),
        .r1_error  (r1_error),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ben   (mem_ben),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall),
        .mem_error (mem_error),
        .dbg_lock  (dbg_lock),
        .dbg_owner (dbg_owner)
    );

    typedef struct packed {
        logic        mem_cen;
        logic        mem_wen;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_ben;
        logic        r0_stall;
        logic        r0_error;
        logic [31:0] r0_rdata;
        logic        r1_stall;
        logic        r1_error;
        logic [31:0] r1_rdata;
        logic        lock;
    } exp_t;

    localparam int EW = $bits(exp_t);
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // g: expected grant (0 none, 1 r0, 2 r1); lk: expected lock state this cycle.
    task automatic cyc(input logic rst_n,
                       input logic c0, input logic w0, input logic [31:0] a0,
                       input logic c1, input logic w1, input logic [31:0] a1,
                       input logic st, input logic er, input logic [31:0] rd,
                       input int g, input logic lk);
        exp_t e;
        logic done;
        @(posedge g_clk);
        #1;
        g_resetn  = rst_n;
        r0_cen    = c0;
        r0_wen    = w0;
        r0_addr   = a0;
        r0_wdata  = a0 ^ 32'hA5A5_0000;
        r0_ben    = 4'hF;
        r1_cen    = c1;
        r1_wen    = w1;
        r1_addr   = a1;
        r1_wdata  = a1 ^ 32'h5A5A_0000;
        r1_ben    = 4'h3;
        mem_stall = st;
        mem_error = er;
        mem_rdata = rd;
        e = '0;
        if (g == 1) begin
            e.mem_cen   = c0;
            e.mem_wen   = w0;
            e.mem_addr  = a0;
            e.mem_wdata = a0 ^ 32'hA5A5_0000;
            e.mem_ben   = 4'hF;
        end else if (g == 2) begin
            e.mem_cen   = c1;
            e.mem_wen   = w1;
            e.mem_addr  = a1;
            e.mem_wdata = a1 ^ 32'h5A5A_0000;
            e.mem_ben   = 4'h3;
        end
        done = e.mem_cen && !st;
        e.r0_stall = (g == 1) ? st : c0;
        e.r1_stall = (g == 2) ? st : c1;
        e.r0_rdata = (g == 1 && done) ? rd : 32'h0;
        e.r1_rdata = (g == 2 && done) ? rd : 32'h0;
        e.r0_error = (g == 1) && done && er;
        e.r1_error = (g == 2) && done && er;
        e.lock     = lk;
        exp_q.push_back(e);
    endtask

    always @(negedge g_clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("mem_cen",   32'(mem_cen),   32'(mon_e.mem_cen));
            chk("mem_wen",   32'(mem_wen),   32'(mon_e.mem_wen));
            chk("mem_addr",  mem_addr,       mon_e.mem_addr);
            chk("mem_wdata", mem_wdata,      mon_e.mem_wdata);
            chk("mem_ben",   32'(mem_ben),   32'(mon_e.mem_ben));
            chk("r0_stall",  32'(r0_stall),  32'(mon_e.r0_stall));
            chk("r0_error",  32'(r0_error),  32'(mon_e.r0_error));
            chk("r0_rdata",  r0_rdata,       mon_e.r0_rdata);
            chk("r1_stall",  32'(r1_stall),  32'(mon_e.r1_stall));
            chk("r1_error",  32'(r1_error),  32'(mon_e.r1_error));
            chk("r1_rdata",  r1_rdata,       mon_e.r1_rdata);
            chk("lock",      32'(dbg_lock),  32'(mon_e.lock));
        end
    end

    initial begin
        int g_rr;
        // Reset, including a request that must pass straight through.
        cyc(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,    0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h80,  1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1234, 1, 1'b0);

        // Contention with single-cycle memory.
        for (int i = 0; i < 4; i++) begin
`ifdef SCARV_COP_ARB_ROUND_ROBIN_EN
            g_rr = (i % 2 == 0) ? 1 : 2;
`else
            g_rr = 1;
`endif
            cyc(1'b1, 1'b1, 1'b0, 32'(32'h10 + i * 4), 1'b1, 1'b1, 32'(32'h20 + i * 4),
                1'b0, 1'b0, 32'(32'h5000 + i), g_rr, 1'b0);
        end

        // Lone r0 read.
        cyc(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1, 1'b0);

        // r1 locked through 3 stall cycles, r0 arrives in the 2nd.
        cyc(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h7777,     2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h7777,     2, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h7777,     2, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'hCAFEF00D, 2, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h600D0001, 1, 1'b0);

        // r0 write with bus error, then an idle cycle with error still driven.
        cyc(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,        1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 0, 1'b0);

        // Reset while r1 holds the lock.
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 1'b1, 1'b0, 32'h0, 2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 1'b1, 1'b0, 32'h0, 2, 1'b1);
`ifdef SCARV_COP_ARB_ROUND_ROBIN_EN
        g_rr = 2;
`else
        g_rr = 1;
`endif
        cyc(1'b0, 1'b1, 1'b0, 32'h3F0, 1'b1, 1'b0, 32'h300, 1'b1, 1'b0, 32'h0, g_rr, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 32'h500, 1'b0, 1'b0, 32'h4444, 1, 1'b0);

        // Owner drops cen while locked; pending r1 follows next cycle.
        cyc(1'b1, 1'b1, 1'b0, 32'h500, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,    1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h600, 1'b0, 1'b0, 32'h9999, 1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h600, 1'b0, 1'b0, 32'h6666, 2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    0, 1'b0);

        repeat (3) @(posedge g_clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
